hilo_pipe: RTL and testbench

HILO_PIPE -- requirements
Module: hilo_pipe

---
 rtl/hilo_pipe_pkg.sv | 19 +
 rtl/hilo_pipe.sv | 112 +++++++++++
 tb/tb_hilo_pipe.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_pipe_pkg.sv
// Shared processor definitions for the HI/LO multiply result pipeline.
package hilo_pipe_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int HILO_LATENCY_DEFAULT = 3;
    localparam int HILO_CNT_W           = 4;

    // Counter preload for a given issue-to-update latency; unused when latency is 1.
    function automatic logic [HILO_CNT_W-1:0] hilo_cnt_load(input int lat);
        int v;
        v = (lat > 1) ? (lat - 2) : 0;
        return HILO_CNT_W'(v);
    endfunction

endpackage

// File: rtl/hilo_pipe.sv
// HI/LO register pair fed by a multiply pipeline, with MTHI/MTLO/MFHI/MFLO access.
// Latency: HI/LO update LATENCY-1 edges after issue (LATENCY=1 writes at the issue edge).
// Backpressure: stall asserts while a multiply is in flight and any HI/LO access is requested.
module hilo_pipe
    import hilo_pipe_pkg::*;
#(
    parameter int Bits    = 32,
    parameter int LATENCY = HILO_LATENCY_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2*Bits-1:0] product,
    input  logic              mult_start,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [Bits-1:0]   wr_data,
    input  logic              mfhi,
    input  logic              mflo,
    output logic [Bits-1:0]   rd_data,
    output logic              stall,
    output logic              busy,
    output logic              done
);

    localparam logic [HILO_CNT_W-1:0] CNT_LOAD = hilo_cnt_load(LATENCY);
    localparam bit                    DIRECT   = (LATENCY == 1);

    state_t                  state_q, state_d;
    logic [HILO_CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*Bits-1:0]       pend_q, pend_d;
    logic [Bits-1:0]         hi_q, hi_d;
    logic [Bits-1:0]         lo_q, lo_d;
    logic                    done_q, done_d;

    assign busy  = (state_q == BUSY);
    assign stall = busy & (mfhi | mflo | mthi | mtlo);
    assign done  = done_q;

    // Reads see the registered value only; a write on this edge shows up next cycle.
    always_comb begin
        rd_data = '0;
        if (mfhi) begin
            rd_data = hi_q;
        end else if (mflo) begin
            rd_data = lo_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        if (mult_start) begin
            // A new issue always wins: it restarts any multiply in flight and drops MT requests.
            if (DIRECT) begin
                hi_d    = product[2*Bits-1:Bits];
                lo_d    = product[Bits-1:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end else begin
                pend_d  = product;
                cnt_d   = CNT_LOAD;
                state_d = BUSY;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mthi && !stall) begin
                        hi_d = wr_data;
                    end
                    if (mtlo && !stall) begin
                        lo_d = wr_data;
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - HILO_CNT_W'(1);
                    end else begin
                        hi_d    = pend_q[2*Bits-1:Bits];
                        lo_d    = pend_q[Bits-1:0];
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_hilo_pipe.sv
// Bench for hilo_pipe: LATENCY=3 and LATENCY=1 instances driven in lockstep against a cycle-deadline model.
module tb_hilo_pipe;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [2*W-1:0] product;
    logic           mult_start, mthi, mtlo, mfhi, mflo;
    logic [W-1:0]   wr_data;

    logic [W-1:0]   rd3, rd1;
    logic           stall3, stall1, busy3, busy1, done3, done1;

    hilo_pipe #(.Bits(W), .LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .product(product), .mult_start(mult_start),
        .mthi(mthi), .mtlo(mtlo), .wr_data(wr_data), .mfhi(mfhi), .mflo(mflo),
        .rd_data(rd3), .stall(stall3), .busy(busy3), .done(done3)
    );

    hilo_pipe #(.Bits(W), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .product(product), .mult_start(mult_start),
        .mthi(mthi), .mtlo(mtlo), .wr_data(wr_data), .mfhi(mfhi), .mflo(mflo),
        .rd_data(rd1), .stall(stall1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    logic [W-1:0] o_rd[2];
    logic         o_stall[2], o_busy[2], o_done[2];
    assign o_rd[0] = rd3;       assign o_rd[1] = rd1;
    assign o_stall[0] = stall3; assign o_stall[1] = stall1;
    assign o_busy[0] = busy3;   assign o_busy[1] = busy1;
    assign o_done[0] = done3;   assign o_done[1] = done1;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a pending result carries an absolute due cycle; it lands when the cycle count reaches it.
    int             m_lat[2] = '{3, 1};
    logic [W-1:0]   m_hi[2], m_lo[2];
    logic [2*W-1:0] m_pend[2];
    bit             m_have[2], m_done[2];
    int             m_due[2];
    int             cyc = 0;

    typedef struct {
        logic           ms;
        logic [2*W-1:0] prod;
        logic           hw, lw;
        logic [W-1:0]   wd;
        logic           fh, fl;
        logic [W-1:0]   e_rd;
        logic           e_busy, e_stall, e_done;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input logic ms, input logic [2*W-1:0] prod, input logic hw, input logic lw,
                                input logic [W-1:0] wd, input logic fh, input logic fl,
                                input logic [W-1:0] e_rd, input logic e_busy, input logic e_stall,
                                input logic e_done);
        vec_t v;
        v.ms = ms; v.prod = prod; v.hw = hw; v.lw = lw; v.wd = wd; v.fh = fh; v.fl = fl;
        v.e_rd = e_rd; v.e_busy = e_busy; v.e_stall = e_stall; v.e_done = e_done;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_hi[i] = '0; m_lo[i] = '0; m_pend[i] = '0;
            m_have[i] = 1'b0; m_done[i] = 1'b0; m_due[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 1'b0;
            if (mult_start) begin
                if (m_lat[i] == 1) begin
                    m_hi[i] = product[2*W-1:W];
                    m_lo[i] = product[W-1:0];
                    m_done[i] = 1'b1;
                    m_have[i] = 1'b0;
                end else begin
                    m_have[i] = 1'b1;
                    m_pend[i] = product;
                    m_due[i]  = cyc + m_lat[i] - 1;
                end
            end else if (m_have[i]) begin
                if (cyc == m_due[i]) begin
                    m_hi[i] = m_pend[i][2*W-1:W];
                    m_lo[i] = m_pend[i][W-1:0];
                    m_done[i] = 1'b1;
                    m_have[i] = 1'b0;
                end
            end else begin
                if (mthi) m_hi[i] = wr_data;
                if (mtlo) m_lo[i] = wr_data;
            end
        end
        cyc++;
    endtask

    task automatic check_models();
        logic [W-1:0] erd;
        logic         est;
        for (int i = 0; i < 2; i++) begin
            erd = mfhi ? m_hi[i] : (mflo ? m_lo[i] : '0);
            est = m_have[i] && (mfhi || mflo || mthi || mtlo);
            chk($sformatf("L%0d rd_data", m_lat[i]), 64'(o_rd[i]), 64'(erd));
            chk($sformatf("L%0d busy", m_lat[i]), 64'(o_busy[i]), 64'(m_have[i]));
            chk($sformatf("L%0d stall", m_lat[i]), 64'(o_stall[i]), 64'(est));
            chk($sformatf("L%0d done", m_lat[i]), 64'(o_done[i]), 64'(m_done[i]));
        end
    endtask

    task automatic drive(input logic ms, input logic [2*W-1:0] pr, input logic hw, input logic lw,
                         input logic [W-1:0] wd, input logic fh, input logic fl);
        mult_start = ms; product = pr; mthi = hw; mtlo = lw; wr_data = wd; mfhi = fh; mflo = fl;
        #3;
    endtask

    task automatic advance(input bit in_reset);
        if (in_reset) model_reset();
        else model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic ms, input logic [2*W-1:0] pr, input logic hw, input logic lw,
                        input logic [W-1:0] wd, input logic fh, input logic fl);
        drive(ms, pr, hw, lw, wd, fh, fl);
        check_models();
        advance(1'b0);
    endtask

    initial begin
        tbl[0]  = mk(1, 64'h0000_0001_FFFF_FFFE, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0);
        tbl[1]  = mk(0, 64'h0,                   0, 0, 32'h0,         1, 0, 32'h0,         1, 1, 0);
        tbl[2]  = mk(0, 64'h0,                   0, 0, 32'h0,         1, 0, 32'h0,         1, 1, 0);
        tbl[3]  = mk(0, 64'h0,                   0, 0, 32'h0,         1, 0, 32'h1,         0, 0, 1);
        tbl[4]  = mk(0, 64'h0,                   0, 0, 32'h0,         0, 1, 32'hFFFF_FFFE, 0, 0, 0);
        tbl[5]  = mk(0, 64'h0,                   1, 0, 32'hDEAD_BEEF, 0, 0, 32'h0,         0, 0, 0);
        tbl[6]  = mk(0, 64'h0,                   0, 0, 32'h0,         1, 0, 32'hDEAD_BEEF, 0, 0, 0);
        tbl[7]  = mk(1, 64'h0000_0005_0000_0007, 1, 0, 32'h1111_1111, 0, 0, 32'h0,         0, 0, 0);
        tbl[8]  = mk(0, 64'h0,                   0, 1, 32'h2222_2222, 0, 0, 32'h0,         1, 1, 0);
        tbl[9]  = mk(0, 64'h0,                   0, 0, 32'h0,         0, 1, 32'hFFFF_FFFE, 1, 1, 0);
        tbl[10] = mk(0, 64'h0,                   0, 0, 32'h0,         0, 1, 32'h7,         0, 0, 1);
        tbl[11] = mk(0, 64'h0,                   0, 0, 32'h0,         1, 0, 32'h5,         0, 0, 0);
        tbl[12] = mk(1, 64'h1,                   0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0);
        tbl[13] = mk(1, 64'h2,                   0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 0);
        tbl[14] = mk(0, 64'h0,                   0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 0);
        tbl[15] = mk(0, 64'h0,                   0, 0, 32'h0,         0, 1, 32'h7,         1, 1, 0);
        tbl[16] = mk(0, 64'h0,                   0, 0, 32'h0,         0, 1, 32'h2,         0, 0, 1);
        tbl[17] = mk(0, 64'h0,                   0, 0, 32'h0,         1, 0, 32'h0,         0, 0, 0);
        tbl[18] = mk(0, 64'h0,                   0, 0, 32'h0,         1, 1, 32'h0,         0, 0, 0);

        // Power-on reset with an explicit falling edge.
        rst_n = 1'b1;
        mult_start = 0; product = '0; mthi = 0; mtlo = 0; wr_data = '0; mfhi = 0; mflo = 0;
        model_reset();
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        drive(0, '0, 0, 0, '0, 1, 0);
        check_models();
        advance(1'b1);
        rst_n = 1'b1;

        // First edge after release with no request changes nothing.
        step(0, '0, 0, 0, '0, 1, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].ms, tbl[i].prod, tbl[i].hw, tbl[i].lw, tbl[i].wd, tbl[i].fh, tbl[i].fl);
            chk($sformatf("vec%0d rd_data", i), 64'(rd3), 64'(tbl[i].e_rd));
            chk($sformatf("vec%0d busy", i), 64'(busy3), 64'(tbl[i].e_busy));
            chk($sformatf("vec%0d stall", i), 64'(stall3), 64'(tbl[i].e_stall));
            chk($sformatf("vec%0d done", i), 64'(done3), 64'(tbl[i].e_done));
            check_models();
            advance(1'b0);
        end

        // Mid-flight reset: the pending result must never appear.
        step(1, 64'hAAAA_AAAA_5555_5555, 0, 0, '0, 0, 0);
        drive(0, '0, 0, 0, '0, 1, 0);
        chk("midreset busy before", 64'(busy3), 64'(1'b1));
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midreset busy", 64'(busy3), 64'(1'b0));
        chk("midreset rd_hi", 64'(rd3), 64'(32'h0));
        check_models();
        advance(1'b1);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(0, '0, 0, 0, '0, k[0], !k[0]);
            chk($sformatf("post-reset done %0d", k), 64'(done3), 64'(1'b0));
            chk($sformatf("post-reset rd %0d", k), 64'(rd3), 64'(32'h0));
            check_models();
            advance(1'b0);
        end

        // Single-cycle build: write at the issue edge, no write-through, never busy.
        drive(1, 64'h0000_0003_0000_0004, 0, 0, '0, 1, 0);
        chk("L1 issue rd old", 64'(rd1), 64'(32'h0));
        chk("L1 issue busy", 64'(busy1), 64'(1'b0));
        check_models();
        advance(1'b0);
        drive(0, '0, 0, 0, '0, 1, 0);
        chk("L1 after rd", 64'(rd1), 64'(32'h3));
        chk("L1 after done", 64'(done1), 64'(1'b1));
        chk("L1 after busy", 64'(busy1), 64'(1'b0));
        check_models();
        advance(1'b0);
        drive(0, '0, 0, 0, '0, 0, 1);
        chk("L1 lo", 64'(rd1), 64'(32'h4));
        chk("L1 done once", 64'(done1), 64'(1'b0));
        check_models();
        advance(1'b0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) == 0, {$urandom, $urandom},
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
